// File: rtl/gate_response_misr.sv
// rtl/gate_response_misr.sv - response compactor that folds netlist output vectors into a MISR
// and compares the final signature against a golden value.
module gate_response_misr #(
  parameter int RESP_W        = 10,
  parameter int SIG_W         = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h002D,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
  parameter int PATTERN_COUNT = 256,
  parameter int CNT_W         = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  input  logic [SIG_W-1:0]  golden,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_accept;
  logic             load_run;
  logic [SIG_W-1:0] sig_next;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PATTERN_COUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    resp_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    load_run    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load_run   = 1'b1;
        end
      end
      RUN: begin
        resp_ready  = 1'b1;
        busy        = 1'b1;
        accept      = resp_valid;
        last_accept = resp_valid && (count == LAST_IDX);
        if (last_accept) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = RUN;
          load_run   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // abort wins over both a start and an accept in the same cycle
    if (abort) begin
      state_next  = IDLE;
      accept      = 1'b0;
      last_accept = 1'b0;
      load_run    = 1'b0;
    end
  end

  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(resp_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= SEED;
      count     <= '0;
      pass      <= 1'b0;
    end else if (abort) begin
      pass <= 1'b0;
    end else if (load_run) begin
      signature <= SEED;
      count     <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      signature <= sig_next;
      if (last_accept) begin
        count <= FULL_CNT;
        pass  <= (sig_next == golden);
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
